// File: rtl/iserdes_word_aligner.sv
// rtl/iserdes_word_aligner.sv - word-boundary aligner behind a 1:8 ISERDES
//
// Registers the parallel ISERDES word, hunts for TRAIN_PATTERN by pulsing
// BITSLIP, confirms the match over MATCH_COUNT consecutive words, then flags
// lock and qualifies the pass-through data.
//
// Ports:
//   clk          CLKDIV-rate clock
//   rst_n        asynchronous active-low reset
//   data_in      raw ISERDES word {Q1..Q8}, Q1 = MSB
//   enable       1 = run alignment, 0 = return to IDLE
//   realign      one-cycle pulse restarting the search
//   bitslip      to ISERDES BITSLIP, one cycle high per slip
//   data_out     registered copy of data_in
//   data_valid   high while locked
//   locked       high while locked
//   align_error  high once the slip budget is exhausted
//   slip_count   slips issued since the search started (saturating)
module iserdes_word_aligner #(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(8'hF0),
  parameter int                    SETTLE_CYCLES = 3,
  parameter int                    MATCH_COUNT   = 16,
  parameter int                    MAX_SLIPS     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  enable,
  input  logic                  realign,
  output logic                  bitslip,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  locked,
  output logic                  align_error,
  output logic [4:0]            slip_count
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int MW = $clog2(MATCH_COUNT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_SETTLE,
    ST_VERIFY,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [4:0]            slip_q, slip_d;
  logic [MW-1:0]         match_q, match_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic                  bitslip_q, locked_q, error_q;
  logic                  match_ok, slips_done;

  assign match_ok   = (data_q == TRAIN_PATTERN);
  assign slips_done = (slip_q == 5'(MAX_SLIPS));

  always_comb begin
    state_d  = state_q;
    slip_d   = slip_q;
    match_d  = match_q;
    settle_d = settle_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (match_ok) begin
          match_d = MW'(1);
          state_d = (MATCH_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
        end else begin
          state_d = slips_done ? ST_FAIL : ST_SLIP;
        end
      end
      ST_SLIP: begin
        if (!slips_done) slip_d = slip_q + 5'd1;
        // Count down to zero so SETTLE occupies exactly SETTLE_CYCLES cycles.
        settle_d = SW'(SETTLE_CYCLES - 1);
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d = ST_CHECK;
        else                settle_d = settle_q - SW'(1);
      end
      ST_VERIFY: begin
        if (match_ok) begin
          match_d = match_q + MW'(1);
          if (match_q == MW'(MATCH_COUNT - 1)) state_d = ST_LOCKED;
        end else begin
          match_d = '0;
          state_d = slips_done ? ST_FAIL : ST_SLIP;
        end
      end
      ST_LOCKED: state_d = ST_LOCKED;
      ST_FAIL:   state_d = ST_FAIL;
      default:   state_d = ST_IDLE;
    endcase

    // enable outranks realign; realign is ignored while already idle.
    if (!enable)                           state_d = ST_IDLE;
    else if (realign && state_q != ST_IDLE) state_d = ST_IDLE;

    // Clearing on entry makes slip_count read 0 during the IDLE cycle itself.
    if (state_d == ST_IDLE) begin
      slip_d   = '0;
      match_d  = '0;
      settle_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      slip_q    <= '0;
      match_q   <= '0;
      settle_q  <= '0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_in;
      slip_q    <= slip_d;
      match_q   <= match_d;
      settle_q  <= settle_d;
      // Decoding the next state keeps the flags registered yet aligned with state_q.
      bitslip_q <= (state_d == ST_SLIP);
      locked_q  <= (state_d == ST_LOCKED);
      error_q   <= (state_d == ST_FAIL);
    end
  end

  assign bitslip     = bitslip_q;
  assign data_out    = data_q;
  assign data_valid  = locked_q;
  assign locked      = locked_q;
  assign align_error = error_q;
  assign slip_count  = slip_q;

endmodule

// File: tb/tb_iserdes_word_aligner.sv
// tb/tb_iserdes_word_aligner.sv - scoreboard bench for iserdes_word_aligner
module tb_iserdes_word_aligner;

  localparam int          SETTLE = 3;
  localparam int          MATCH  = 16;
  localparam int          MAXS   = 16;
  localparam logic [7:0]  TRAIN  = 8'hF0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       enable = 1'b0;
  logic       realign = 1'b0;
  logic       bitslip;
  logic [7:0] data_out;
  logic       data_valid;
  logic       locked;
  logic       align_error;
  logic [4:0] slip_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] raw = 8'h00;
  int         iser_slips = 0;
  int         corrupt_in = -1;
  logic [7:0] exp_q[$];
  int         gap = 99;

  iserdes_word_aligner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .enable     (enable),
    .realign    (realign),
    .bitslip    (bitslip),
    .data_out   (data_out),
    .data_valid (data_valid),
    .locked     (locked),
    .align_error(align_error),
    .slip_count (slip_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    int k;
    k = n % 8;
    d = {v, v};
    return d[15-k -: 8];
  endfunction

  // Fewest left rotations that turn the raw word into the training pattern.
  function automatic int slips_needed(input logic [7:0] v);
    for (int k = 0; k <= MAXS; k++)
      if (rotl8(v, k) == TRAIN) return k;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ISERDES model: each observed BITSLIP pulse rotates the word left by one.
  always @(negedge clk)
    if (rst_n && bitslip) iser_slips = iser_slips + 1;

  // Driver: presents the ISERDES word and records what data_out must echo.
  always begin
    logic [7:0] w;
    @(posedge clk);
    #1;
    w = (corrupt_in == 0) ? 8'h00 : rotl8(raw, iser_slips);
    if (corrupt_in >= 0) corrupt_in = corrupt_in - 1;
    data_in = w;
    if (rst_n) exp_q.push_back(w);
  end

  // Monitor: pops one expected word per cycle, compares while data_valid.
  always @(negedge clk) begin
    logic [7:0] w;
    if (!rst_n) begin
      exp_q.delete();
      gap = 99;
    end else begin
      if (exp_q.size() >= 2) begin
        w = exp_q.pop_front();
        if (data_valid) chk("data_out", 32'(data_out), 32'(w));
      end
      if (bitslip) begin
        chk("bitslip_quiet_gap", 32'(gap >= SETTLE), 32'd1);
        gap = 0;
      end else if (gap < 99) begin
        gap = gap + 1;
      end
    end
  end

  // Prepare raw word with a fresh ISERDES, enable, and wait for lock.
  task automatic search_lock(input string nm, input logic [7:0] r, input int exp_slips,
                             input int exp_lat, input int corrupt);
    int cyc;
    logic got;
    enable = 1'b0;
    raw = r;
    iser_slips = 0;
    tick(); tick(); tick();
    #1;
    enable = 1'b1;
    corrupt_in = corrupt;
    cyc = 0;
    got = 1'b0;
    while (cyc < 400 && !got) begin
      tick();
      cyc++;
      got = locked;
    end
    chk({nm, "_lock_seen"}, 32'(got), 32'd1);
    chk({nm, "_lock_latency"}, 32'(cyc), 32'(exp_lat));
    chk({nm, "_slip_count"}, 32'(slip_count), 32'(exp_slips));
    chk({nm, "_data_valid"}, 32'(data_valid), 32'd1);
    chk({nm, "_data_out"}, 32'(data_out), 32'(TRAIN));
    #1;
  endtask

  initial begin
    int k;
    int cyc;
    logic got;

    // Reset state
    tick(); tick();
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_error", 32'(align_error), 32'd0);
    chk("rst_bitslip", 32'(bitslip), 32'd0);
    chk("rst_slip_count", 32'(slip_count), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    #1;
    rst_n = 1'b1;

    // 1: already aligned, lock after one IDLE cycle plus MATCH compares
    search_lock("t1", TRAIN, 0, 1 + MATCH, -1);

    // 5: payload while locked, then enable drop
    for (int i = 0; i < 40; i++) begin
      raw = 8'($urandom_range(8'h3C, 8'hC3));
      tick();
      chk("t5_lock_held", 32'(locked), 32'd1);
      #1;
    end
    enable = 1'b0;
    tick();
    chk("t5_locked_drop", 32'(locked), 32'd0);
    chk("t5_valid_drop", 32'(data_valid), 32'd0);
    #1;

    // 2: 4-bit offset; every slip round costs CHECK + SLIP + SETTLE cycles
    k = slips_needed(8'h0F);
    search_lock("t2", 8'h0F, k, 1 + k * (2 + SETTLE) + MATCH, -1);

    // 2b: a random offset of the training pattern
    k = $urandom_range(1, 7);
    search_lock("t2b", rotl8(TRAIN, 8 - k), k, 1 + k * (2 + SETTLE) + MATCH, -1);

    // 4: word at match 10 corrupted -> one slip from VERIFY, seven more to wrap
    //    around the byte, then a full fresh run of matches
    search_lock("t4", TRAIN, 8, 1 + 11 + (1 + SETTLE) + 7 * (2 + SETTLE) + MATCH, 9);

    // 3: never matches -> FAIL after MAXS slips, realign restarts
    enable = 1'b0;
    raw = 8'hAA;
    iser_slips = 0;
    tick(); tick();
    #1;
    enable = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (cyc < 400 && !got) begin
      tick();
      cyc++;
      got = align_error;
    end
    chk("t3_error_seen", 32'(got), 32'd1);
    chk("t3_error_latency", 32'(cyc), 32'(1 + MAXS * (2 + SETTLE) + 1));
    chk("t3_slip_count", 32'(slip_count), 32'(MAXS));
    chk("t3_locked", 32'(locked), 32'd0);
    tick();
    chk("t3_error_held", 32'(align_error), 32'd1);
    #1;
    realign = 1'b1;
    tick();
    chk("t3_realign_error", 32'(align_error), 32'd0);
    chk("t3_realign_slips", 32'(slip_count), 32'd0);
    #1;
    realign = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (cyc < 20 && !got) begin
      tick();
      cyc++;
      got = bitslip;
    end
    chk("t3_restart_slip", 32'(got), 32'd1);
    chk("t3_restart_count", 32'(slip_count), 32'd0);
    #1;
    enable = 1'b0;
    tick(); tick(); tick();
    #1;

    // 6: async reset in SETTLE, search restarts from zero
    raw = 8'h0F;
    iser_slips = 0;
    tick(); tick();
    #1;
    enable = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (cyc < 20 && !got) begin
      tick();
      cyc++;
      got = bitslip;
    end
    chk("t6_first_slip", 32'(got), 32'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_bitslip", 32'(bitslip), 32'd0);
    chk("t6_rst_slip_count", 32'(slip_count), 32'd0);
    chk("t6_rst_data_out", 32'(data_out), 32'd0);
    chk("t6_rst_locked", 32'(locked), 32'd0);
    chk("t6_rst_error", 32'(align_error), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    k = slips_needed(rotl8(8'h0F, 1));
    cyc = 0;
    got = 1'b0;
    while (cyc < 400 && !got) begin
      tick();
      cyc++;
      got = locked;
    end
    chk("t6_lock_seen", 32'(got), 32'd1);
    chk("t6_lock_latency", 32'(cyc), 32'(1 + k * (2 + SETTLE) + MATCH));
    chk("t6_slip_count", 32'(slip_count), 32'(k));
    #1;
    enable = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
